// File: rtl/lsu_access.sv
// Load/store unit: one 64-bit-aligned memory access in flight, byte-lane
// formatting for stores and sign/zero extension for loads.
module lsu_access #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [3:0]        req_wdt,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_RESP  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic [2:0] state;
    logic [2:0] off_r;
    logic [3:0] wdt_r;
    logic       uns_r;
    logic       load_r;
    logic [4:0] rd_r;

    logic [2:0] req_off;
    logic       take;
    logic       legal;
    logic       aligned;

    function automatic logic is_aligned(input logic [3:0] wdt, input logic [2:0] off);
        is_aligned = wdt[0]
                   | (wdt[1] & ~off[0])
                   | (wdt[2] & (off[1:0] == 2'b00))
                   | (wdt[3] & (off == 3'b000));
    endfunction

    function automatic logic [7:0] store_mask(input logic [3:0] wdt, input logic [2:0] off);
        logic [7:0] base;
        base = 8'h00;
        case (1'b1)
            wdt[0]:  base = 8'h01;
            wdt[1]:  base = 8'h03;
            wdt[2]:  base = 8'h0F;
            wdt[3]:  base = 8'hFF;
            default: base = 8'h00;
        endcase
        store_mask = base << off;
    endfunction

    // Truncate the lane-shifted word to the access width, then extend.
    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] sh,
                                                      input logic [3:0] wdt,
                                                      input logic uns);
        logic [DATA_W-1:0] r;
        r = sh;
        case (1'b1)
            wdt[0]:  r = {{(DATA_W-8){sh[7] & ~uns}}, sh[7:0]};
            wdt[1]:  r = {{(DATA_W-16){sh[15] & ~uns}}, sh[15:0]};
            wdt[2]:  r = {{(DATA_W-32){sh[31] & ~uns}}, sh[31:0]};
            default: r = sh;
        endcase
        extend_load = r;
    endfunction

    assign req_off       = req_addr[2:0];
    assign req_ready     = (state == S_IDLE);
    assign mem_req_valid = (state == S_REQ);
    assign take          = req_valid & req_ready;
    assign legal         = (req_load ^ req_store) & $onehot(req_wdt);
    assign aligned       = is_aligned(req_wdt, req_off);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wb_valid  <= 1'b0;
            misalign  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            mem_wen   <= 1'b0;
            mem_wmask <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take) begin
                        if (legal && aligned) begin
                            state     <= S_REQ;
                            mem_wen   <= req_store;
                            mem_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
                            mem_wdata <= req_store ? (req_wdata << {req_off, 3'b000}) : '0;
                            mem_wmask <= req_store ? store_mask(req_wdt, req_off) : 8'h00;
                        end else begin
                            state    <= S_FAULT;
                            misalign <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) state <= S_RESP;
                end
                S_RESP: begin
                    if (mem_resp_valid) begin
                        state    <= S_DONE;
                        wb_valid <= 1'b1;
                        wb_rd    <= load_r ? rd_r : 5'd0;
                        wb_data  <= load_r ? extend_load(mem_rdata >> {off_r, 3'b000}, wdt_r, uns_r) : '0;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_FAULT: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Request attributes needed only at response time; no reset required.
    always_ff @(posedge clk) begin
        if (take) begin
            off_r  <= req_off;
            wdt_r  <= req_wdt;
            uns_r  <= req_unsigned;
            load_r <= req_load;
            rd_r   <= req_rd;
        end
    end

endmodule

// File: tb/tb_lsu_access.sv
// Directed bench for lsu_access: loads, stores, backpressure, faults, reset abort.
module tb_lsu_access;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_load = 1'b0;
    logic        req_store = 1'b0;
    logic [3:0]  req_wdt = 4'b0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_wen;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        misalign;

    int n_cmp = 0;
    int n_err = 0;

    lsu_access #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .req_wdt(req_wdt),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [3:0] wdt, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_load     = ld;
        req_store    = st;
        req_wdt      = wdt;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_rd       = rd;
        tick();
        req_valid = 1'b0;
        req_load  = 1'b0;
        req_store = 1'b0;
    endtask

    // Called in REQ: request handshake, then response one cycle later; returns in DONE.
    task automatic do_mem(input logic [63:0] rdata);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = rdata;
        tick();
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        #1;
        chk("rst_mem_req_valid", {63'b0, mem_req_valid}, 64'd0);
        tick();
        chk("rst_wb_valid", {63'b0, wb_valid}, 64'd0);
        chk("rst_misalign", {63'b0, misalign}, 64'd0);
        chk("rst_wb_rd", {59'b0, wb_rd}, 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_mem_wen", {63'b0, mem_wen}, 64'd0);
        chk("rst_mem_wmask", {56'b0, mem_wmask}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_req_ready", {63'b0, req_ready}, 64'd1);

        // lb with sign, latency check
        issue(1'b1, 1'b0, 4'b0001, 1'b0, 64'h8000_0003, 64'd0, 5'd5);
        chk("lb_mem_req_valid", {63'b0, mem_req_valid}, 64'd1);
        chk("lb_req_ready", {63'b0, req_ready}, 64'd0);
        chk("lb_mem_addr", mem_addr, 64'h8000_0000);
        chk("lb_mem_wmask", {56'b0, mem_wmask}, 64'd0);
        chk("lb_mem_wen", {63'b0, mem_wen}, 64'd0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        chk("lb_c2_mem_req_valid", {63'b0, mem_req_valid}, 64'd0);
        chk("lb_c2_wb_valid", {63'b0, wb_valid}, 64'd0);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h0000_0000_8000_0000;
        tick();
        mem_resp_valid = 1'b0;
        chk("lb_c3_wb_valid", {63'b0, wb_valid}, 64'd1);
        chk("lb_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_wb_rd", {59'b0, wb_rd}, 64'd5);

        // lhu issued back-to-back in the cycle after DONE
        tick();
        chk("done_wb_valid_pulse", {63'b0, wb_valid}, 64'd0);
        chk("done_req_ready", {63'b0, req_ready}, 64'd1);
        issue(1'b1, 1'b0, 4'b0010, 1'b1, 64'h8000_0006, 64'd0, 5'd6);
        do_mem(64'hBEEF_0000_0000_0000);
        chk("lhu_wb_data", wb_data, 64'h0000_0000_0000_BEEF);
        tick();
        issue(1'b1, 1'b0, 4'b0010, 1'b0, 64'h8000_0006, 64'd0, 5'd6);
        do_mem(64'hBEEF_0000_0000_0000);
        chk("lh_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_BEEF);
        tick();

        // lw / lwu at upper word
        issue(1'b1, 1'b0, 4'b0100, 1'b0, 64'h8000_0004, 64'd0, 5'd9);
        do_mem(64'h8765_4321_0000_0000);
        chk("lw_wb_data", wb_data, 64'hFFFF_FFFF_8765_4321);
        tick();
        issue(1'b1, 1'b0, 4'b0100, 1'b1, 64'h8000_0004, 64'd0, 5'd9);
        do_mem(64'h8765_4321_0000_0000);
        chk("lwu_wb_data", wb_data, 64'h0000_0000_8765_4321);
        tick();

        // sw
        issue(1'b0, 1'b1, 4'b0100, 1'b0, 64'h8000_0004, 64'h0000_0000_1234_5678, 5'd7);
        chk("sw_mem_wen", {63'b0, mem_wen}, 64'd1);
        chk("sw_mem_wmask", {56'b0, mem_wmask}, 64'hF0);
        chk("sw_mem_wdata_hi", {32'b0, mem_wdata[63:32]}, 64'h1234_5678);
        chk("sw_mem_addr", mem_addr, 64'h8000_0000);
        do_mem(64'hDEAD_BEEF_DEAD_BEEF);
        chk("sw_wb_valid", {63'b0, wb_valid}, 64'd1);
        chk("sw_wb_rd", {59'b0, wb_rd}, 64'd0);
        chk("sw_wb_data", wb_data, 64'd0);
        tick();

        // sb at offset 5
        issue(1'b0, 1'b1, 4'b0001, 1'b0, 64'h8000_0015, 64'h0000_0000_0000_00AB, 5'd3);
        chk("sb_mem_wmask", {56'b0, mem_wmask}, 64'h20);
        chk("sb_mem_wdata", mem_wdata, 64'h0000_AB00_0000_0000);
        chk("sb_mem_addr", mem_addr, 64'h8000_0010);
        do_mem(64'd0);
        tick();

        // sd with backpressure
        issue(1'b0, 1'b1, 4'b1000, 1'b0, 64'h8000_0010, 64'hA5A5_5A5A_0123_4567, 5'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_mem_req_valid", {63'b0, mem_req_valid}, 64'd1);
            chk("bp_req_ready", {63'b0, req_ready}, 64'd0);
            chk("bp_mem_addr", mem_addr, 64'h8000_0010);
            chk("bp_mem_wmask", {56'b0, mem_wmask}, 64'hFF);
            chk("bp_mem_wdata", mem_wdata, 64'hA5A5_5A5A_0123_4567);
            chk("bp_wb_valid", {63'b0, wb_valid}, 64'd0);
        end
        do_mem(64'd0);
        chk("bp_wb_valid_once", {63'b0, wb_valid}, 64'd1);
        tick();
        chk("bp_wb_valid_end", {63'b0, wb_valid}, 64'd0);

        // Misaligned ld
        issue(1'b1, 1'b0, 4'b1000, 1'b0, 64'h8000_0004, 64'd0, 5'd4);
        chk("mis_misalign", {63'b0, misalign}, 64'd1);
        chk("mis_mem_req_valid", {63'b0, mem_req_valid}, 64'd0);
        chk("mis_wb_valid", {63'b0, wb_valid}, 64'd0);
        chk("mis_req_ready", {63'b0, req_ready}, 64'd0);
        tick();
        chk("mis_misalign_end", {63'b0, misalign}, 64'd0);
        chk("mis_mem_req_valid_end", {63'b0, mem_req_valid}, 64'd0);
        chk("mis_req_ready_end", {63'b0, req_ready}, 64'd1);
        issue(1'b1, 1'b0, 4'b1000, 1'b1, 64'h8000_0008, 64'd0, 5'd12);
        chk("ld_mem_addr", mem_addr, 64'h8000_0008);
        do_mem(64'h8123_4567_89AB_CDEF);
        chk("ld_wb_data", wb_data, 64'h8123_4567_89AB_CDEF);
        chk("ld_wb_rd", {59'b0, wb_rd}, 64'd12);
        tick();

        // Illegal: both load and store
        issue(1'b1, 1'b1, 4'b0001, 1'b0, 64'h8000_0000, 64'd0, 5'd2);
        chk("ill_misalign", {63'b0, misalign}, 64'd1);
        chk("ill_mem_req_valid", {63'b0, mem_req_valid}, 64'd0);
        tick();
        // Illegal: width not one-hot
        issue(1'b1, 1'b0, 4'b0011, 1'b0, 64'h8000_0000, 64'd0, 5'd2);
        chk("ill_wdt_misalign", {63'b0, misalign}, 64'd1);
        tick();

        // Reset during RESP of a store
        issue(1'b0, 1'b1, 4'b0100, 1'b0, 64'h8000_0004, 64'h0000_0000_CAFE_F00D, 5'd8);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_mem_wen", {63'b0, mem_wen}, 64'd0);
        chk("abort_mem_wmask", {56'b0, mem_wmask}, 64'd0);
        chk("abort_mem_addr", mem_addr, 64'd0);
        chk("abort_mem_wdata", mem_wdata, 64'd0);
        chk("abort_wb_data", wb_data, 64'd0);
        chk("abort_mem_req_valid", {63'b0, mem_req_valid}, 64'd0);
        tick();
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_resp_valid = 1'b0;
        chk("late_resp_wb_valid", {63'b0, wb_valid}, 64'd0);
        tick();
        chk("late_resp_wb_valid2", {63'b0, wb_valid}, 64'd0);
        chk("late_resp_req_ready", {63'b0, req_ready}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_access.md
Name: lsu_access

Overview:
- Load/store unit. Consumes the decoder's memory-control outputs (mem_wen, is_load, wdt_op, is_unsigned) plus the EXU-computed address and store data.
- Issues one 64-bit-aligned memory transaction per instruction over a valid/ready request and valid response bus.
- Returns sign- or zero-extended load data to writeback.
- Sits between EXU and the data memory; one access in flight at a time.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width (fixed 64; byte lanes = 8)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  EXU presents an access
- req_ready  out  1  LSU accepts access (IDLE only)
- req_load  in  1  access is a load (decoder is_load)
- req_store  in  1  access is a store (decoder mem_wen)
- req_wdt  in  4  one-hot width: bit0=8b, bit1=16b, bit2=32b, bit3=64b
- req_unsigned  in  1  zero-extend load (lbu/lhu/lwu)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, LSB-justified
- req_rd  in  5  destination register
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_wen  out  1  1=write, 0=read
- mem_addr  out  ADDR_W  req_addr with [2:0] cleared
- mem_wdata  out  DATA_W  store data shifted to byte lane
- mem_wmask  out  8  byte-enable for writes; 0 for reads
- mem_resp_valid  in  1  read data / write ack valid
- mem_rdata  in  DATA_W  aligned 64-bit read data
- wb_valid  out  1  one-cycle completion pulse
- wb_rd  out  5  destination register (0 for stores)
- wb_data  out  DATA_W  extended load result (0 for stores)
- misalign  out  1  one-cycle pulse: access rejected as misaligned

Behaviour:
- Reset (async, rst=1): state=IDLE. Outputs: mem_req_valid=0, wb_valid=0, misalign=0, wb_rd=0, wb_data=0, mem_wen=0, mem_wmask=0, mem_addr=0, mem_wdata=0. req_ready=1 after reset deasserts.
- Accept: in IDLE, req_ready=1. Fire = req_valid & req_ready & (req_load ^ req_store). Fire latches all req_* fields into registers.
- Illegal request: req_valid with both or neither of req_load/req_store, or req_wdt not one-hot. The request is consumed, no memory access is issued, and misalign pulses next cycle.
- Alignment: off = addr[2:0]. Legal offsets are any for 8b, off[0]=0 for 16b, off[1:0]=0 for 32b, off=0 for 64b.
- Misaligned fire: state goes to FAULT for 1 cycle; misalign=1, wb_valid=0; then IDLE. No memory request is issued.
- States: IDLE -> REQ on aligned fire. REQ holds mem_req_valid=1 and stable outputs until mem_req_ready. REQ -> RESP on handshake. RESP waits for mem_resp_valid. RESP -> DONE. DONE pulses wb_valid for 1 cycle, then -> IDLE.
- Minimum latency: fire at cycle 0; mem_req_valid at cycle 1; with ready=1 and resp in the next cycle, wb_valid at cycle 3.
- Store formatting:
  - base mask is 0x01, 0x03, 0x0F or 0xFF for 8b, 16b, 32b or 64b.
  - mem_wmask = base << off.
  - mem_wdata = req_wdata << (8*off); bits above the width are don't-care but are masked off by wmask.
- Load extract:
  - sh = mem_rdata >> (8*off), captured on mem_resp_valid.
  - The value is truncated to the width, then sign-extended from the top bit, or zero-extended if req_unsigned.
  - 64b ignores req_unsigned.
- mem_resp_valid outside RESP is ignored. mem_req_ready outside REQ is ignored.
- Response in same cycle as request handshake is not supported; the response is sampled only in RESP.
- Stores: wb_valid still pulses on ack, with wb_rd=0 and wb_data=0 (retire signal).
- req_ready=0 in REQ/RESP/DONE/FAULT; back-to-back accept possible in the cycle after DONE.
- Reset mid-transaction: aborts immediately to IDLE. No wb_valid or misalign for the aborted access. Any later response is ignored.

Test Plan:
- Load, lb with sign: addr=0x8000_0003, mem_rdata=0x0000_0000_8000_0000 -> mem_addr=0x8000_0000, mem_wmask=0, wb_data=0xFFFF_FFFF_FFFF_FF80, wb_valid 3 cycles after fire.
- Load, lhu: addr=0x8000_0006, mem_rdata=0xBEEF_0000_0000_0000 -> wb_data=0x0000_0000_0000_BEEF. Same access as lh -> 0xFFFF_FFFF_FFFF_BEEF.
- Store, sw: addr=0x8000_0004, wdata=0x1234_5678 -> mem_wen=1, mem_wmask=0xF0, mem_wdata[63:32]=0x1234_5678. Then wb_valid with wb_rd=0.
- Backpressure: mem_req_ready low 4 cycles -> mem_req_valid held, address/data/mask stable, req_ready=0 throughout, single wb_valid.
- Misaligned access: ld at 0x8000_0004 -> misalign pulses 1 cycle, no mem_req_valid, wb_valid stays 0. Next aligned ld proceeds normally.
- Reset mid-transaction: assert rst during RESP -> all outputs 0 asynchronously. A late mem_resp_valid after reset produces no wb_valid.
